// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: matches the latched BCD mm:ss alarm on second ticks, rings with a
// divided buzzer, handles dismiss/timeout and optional snooze (define ALARM_SNOOZE_EN).
module alarm_ring_controller #(
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned BEEP_DIV   = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic [15:0] time_now,
  input  logic [15:0] alarm,
  input  logic        armed,
  input  logic        dismiss,
  input  logic        snooze,
  output logic [1:0]  state,
  output logic        ringing,
  output logic        beep,
  output logic [15:0] target,
  output logic [3:0]  snooze_cnt,
  output logic        missed
);

  localparam int unsigned BeepW = $clog2(BEEP_DIV);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRinging = 2'd2,
    StSnooze  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      target_q, target_d;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [BeepW-1:0] beep_div_q, beep_div_d;
  logic             beep_q, beep_d;
  logic             missed_q, missed_d;
  logic             match, timeout;

  assign match   = sec_tick && (time_now == target_q);
  assign timeout = sec_tick && (ring_cnt_q == 8'(RING_SEC - 1));

`ifdef ALARM_SNOOZE_EN
  logic [3:0]  snooze_cnt_q, snooze_cnt_d;
  logic [4:0]  ones_sum, tens_sum;
  logic [3:0]  ones_new, tens_new;
  logic        carry;
  logic        snooze_ok;
  logic [15:0] snooze_target;

  // Minute-only BCD add; any tens result of 6 or more wraps to 0
  always_comb begin
    ones_sum = {1'b0, target_q[11:8]} + 5'(SNOOZE_MIN);
    carry    = (ones_sum >= 5'd10);
    ones_new = carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    tens_sum = {1'b0, target_q[15:12]} + {4'd0, carry};
    tens_new = (tens_sum >= 5'd6) ? 4'd0 : tens_sum[3:0];
  end

  assign snooze_target = {tens_new, ones_new, target_q[7:0]};
  assign snooze_ok     = snooze && (snooze_cnt_q < 4'(MAX_SNOOZE));
  assign snooze_cnt    = snooze_cnt_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snooze_cnt    = 4'd0;
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    ring_cnt_d = ring_cnt_q;
    missed_d   = missed_q;
    beep_d     = beep_q;
    beep_div_d = beep_div_q;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif
    if (!armed) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StArmed;
          target_d = alarm;
`ifdef ALARM_SNOOZE_EN
          snooze_cnt_d = 4'd0;
`endif
        end
        StArmed: begin
          if (match) begin
            state_d    = StRinging;
            ring_cnt_d = 8'd0;
          end
        end
        StRinging: begin
          if (sec_tick) ring_cnt_d = ring_cnt_q + 8'd1;
          if (dismiss || timeout) begin
            state_d  = StArmed;
            target_d = alarm;
            missed_d = !dismiss;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_d = 4'd0;
          end else if (snooze_ok) begin
            state_d      = StSnooze;
            target_d     = snooze_target;
            snooze_cnt_d = snooze_cnt_q + 4'd1;
`endif
          end
        end
        StSnooze: begin
          if (dismiss) begin
            state_d  = StArmed;
            target_d = alarm;
            missed_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_d = 4'd0;
`endif
          end else if (match) begin
            state_d    = StRinging;
            ring_cnt_d = 8'd0;
          end
        end
      endcase
    end

    // Divider restarts on every entry to RINGING and is parked outside it
    if (state_d != StRinging || state_q != StRinging) begin
      beep_d     = 1'b0;
      beep_div_d = '0;
    end else if (beep_div_q == BeepW'(BEEP_DIV - 1)) begin
      beep_d     = ~beep_q;
      beep_div_d = '0;
    end else begin
      beep_div_d = beep_div_q + BeepW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      target_q   <= 16'd0;
      ring_cnt_q <= 8'd0;
      beep_div_q <= '0;
      beep_q     <= 1'b0;
      missed_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      ring_cnt_q <= ring_cnt_d;
      beep_div_q <= beep_div_d;
      beep_q     <= beep_d;
      missed_q   <= missed_d;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= snooze_cnt_d;
`endif
    end
  end

  assign state   = state_q;
  assign ringing = (state_q == StRinging);
  assign beep    = beep_q;
  assign target  = target_q;
  assign missed  = missed_q;

endmodule
